// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and sizing helper
// for the multi-digit seven-segment display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_e;

    // ceil(width*log10(2) + 1), log10(2) ~= 0.30103
    function automatic int bcd_nibbles(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/seg7_multi_display_seg7.sv
// seg7: BCD digit to active-low segments (bit0=a .. bit6=g).
// Ports: bcd_i [3:0] digit in, seg_o [6:0] segments out.
import seg7_pkg::*;

module seg7 (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_multi_display.sv
// seg7_multi_display: binary -> BCD (serial double-dabble) -> HEX.
// Ports: clk, reset (sync, high), value/load in, lzb_en/blink_en
// live gating, busy/done status, leds [DIGITS-1:0][6:0] active-low.
import seg7_pkg::*;

module seg7_multi_display #(
    parameter int WIDTH     = 10,
    parameter int DIGITS    = 3,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       value,
    input  logic                   load,
    input  logic                   lzb_en,
    input  logic                   blink_en,
    output logic                   busy,
    output logic                   done,
    output logic [DIGITS-1:0][6:0] leds
);

    localparam int    NIB  = bcd_nibbles(WIDTH);
    localparam int    BW   = 4 * NIB;
    localparam int    CNTW = $clog2(WIDTH);
    localparam int    BDW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam longint MAXV = longint'(10 ** DIGITS) - 1;

    state_e                  state_q;
    logic [CNTW-1:0]         cnt_q;
    logic [WIDTH-1:0]        bin_q, bin_d;
    logic [BW-1:0]           bcd_q, bcd_d, bcd_adj;
    logic                    ovf_q, dovf_q, shown_q;
    logic                    done_q, busy_q;
    logic [DIGITS-1:0][3:0]  dig_q, bcd_dig;
    logic [DIGITS-1:0][6:0]  seg_raw;
    logic [DIGITS-1:0]       lz;
    logic                    lead;
    logic [BDW-1:0]          bcnt_q;
    logic                    phase_q;

    // add-3 correction, then shift {bcd, bin} left by one
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < NIB; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
        end
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
    end

    // digits beyond the accumulator width read as zero
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i < NIB) begin : g_in
            assign bcd_dig[i] = bcd_q[4*i +: 4];
        end else begin : g_out
            assign bcd_dig[i] = 4'd0;
        end
        seg7 u_seg (
            .bcd_i (dig_q[i]),
            .seg_o (seg_raw[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dig_q   <= '0;
            dovf_q  <= 1'b0;
            shown_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        bin_q   <= value;
                        bcd_q   <= '0;
                        ovf_q   <= 64'(value) > 64'(MAXV);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNTW'(WIDTH - 1))
                        state_q <= UPDATE;
                end
                UPDATE: begin
                    dig_q   <= bcd_dig;
                    dovf_q  <= ovf_q;
                    shown_q <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else if (bcnt_q == BDW'(BLINK_DIV - 1)) begin
            bcnt_q  <= '0;
            phase_q <= ~phase_q;
        end else begin
            bcnt_q <= bcnt_q + 1'b1;
        end
    end

    // lz[i]: digit i and everything above it are zero
    always_comb begin
        lead = 1'b1;
        lz   = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead  = lead & (dig_q[i] == 4'd0);
            lz[i] = lead;
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            if (!shown_q || (blink_en && phase_q))
                leds[i] = SEG_BLANK;
            else if (dovf_q)
                leds[i] = SEG_DASH;
            else if (lzb_en && lz[i])
                leds[i] = SEG_BLANK;
            else
                leds[i] = seg_raw[i];
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule
